// File: rtl/nes_controller_responder_pkg.sv
// Shared definitions for the NES gamepad responder: FSM state encoding,
// button bit positions and frame length.
package nes_pkg;

    localparam int NES_FRAME_BITS = 8;

    // Index of the last bit in a frame; the pulse that advances past it ends the frame.
    localparam logic [2:0] NES_LAST_BIT = 3'(NES_FRAME_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } nes_state_t;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_controller_responder_sync_edge.sv
// Synchronizer plus registered edge detector for one asynchronous host pin.
// sync_out, rise and fall are mutually aligned: when rise is high, sync_out
// is already high in the same cycle. Pin-to-edge latency is SYNC_STAGES+1.
module nes_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync_last;

    assign w_sync_last = r_sync[SYNC_STAGES-1];

    // Metastability chain, delayed level and registered edge strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage sample the previous
            // stage's old value; blocking here would collapse the chain into one flop.
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= w_sync_last;
            r_rise <= w_sync_last & ~r_prev;
            r_fall <= ~w_sync_last & r_prev;
        end
    end

    assign sync_out = r_prev;
    assign rise     = r_rise;
    assign fall     = r_fall;

endmodule

// File: rtl/nes_controller_responder.sv
// Device-side NES gamepad: captures the local buttons while the host holds
// latch high, then shifts them out active-low, one bit per host pulse rise.
// Optional build macro NES_TIMEOUT_EN adds an inactivity watchdog that
// returns to IDLE after TIMEOUT_CYCLES quiet cycles inside a frame.
module nes_controller_responder
    import nes_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       nes_latch,
    input  logic       nes_pulse,
    input  logic [7:0] buttons,
    output logic       nes_data,
    output logic       busy,
    output logic       frame_done,
    output logic [2:0] bit_index
);

    logic w_latch_sync, w_latch_rise, w_latch_fall;
    logic w_pulse_sync, w_pulse_rise, w_pulse_fall;
    logic w_timeout;

    nes_state_t r_state;
    logic [7:0] r_shreg;
    logic       r_data;
    logic       r_busy;
    logic       r_done;
    logic [2:0] r_idx;

    nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (nes_latch),
        .sync_out (w_latch_sync),
        .rise     (w_latch_rise),
        .fall     (w_latch_fall)
    );

    nes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_pulse_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (nes_pulse),
        .sync_out (w_pulse_sync),
        .rise     (w_pulse_rise),
        .fall     (w_pulse_fall)
    );

    // The pulse level itself carries no information beyond its edges.
    logic w_unused_pulse_level;
    assign w_unused_pulse_level = w_pulse_sync;

`ifdef NES_TIMEOUT_EN
    logic [15:0] r_idle_cnt;
    logic        w_any_edge;

    assign w_any_edge = w_latch_rise | w_latch_fall | w_pulse_rise | w_pulse_fall;
    assign w_timeout  = r_busy && !w_any_edge && (r_idle_cnt == 16'(TIMEOUT_CYCLES - 1));

    // Count quiet cycles inside a frame; any host edge restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (w_any_edge || !r_busy || w_timeout) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 16'd1;
        end
    end
`else
    // Without the watchdog a frame waits forever and the pulse fall is unused.
    logic w_unused_pulse_fall;
    assign w_timeout           = 1'b0;
    assign w_unused_pulse_fall = w_pulse_fall;
`endif

    // Frame FSM: latch rise always restarts, then load, shift, done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_shreg <= 8'hFF;
            r_data  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_idx   <= 3'd0;
        end else begin
            // NOTE: frame_done defaults low every cycle so it can only ever be a one-cycle strobe.
            r_done <= 1'b0;
            if (w_latch_rise) begin
                // Wins over any simultaneous pulse edge and aborts a partial frame.
                r_state <= LOAD;
                r_shreg <= ~buttons;
                r_data  <= ~buttons[BTN_A];
                r_busy  <= 1'b1;
                r_idx   <= 3'd0;
            end else if (w_timeout) begin
                r_state <= IDLE;
                r_shreg <= 8'hFF;
                r_data  <= 1'b1;
                r_busy  <= 1'b0;
                r_idx   <= 3'd0;
            end else begin
                case (r_state)
                    LOAD: begin
                        if (w_latch_fall) begin
                            r_state <= SHIFT;
                            r_idx   <= 3'd0;
                        end else if (w_latch_sync) begin
                            // Keep tracking the buttons; the last latch-high sample is the one shifted.
                            r_shreg <= ~buttons;
                            r_data  <= ~buttons[BTN_A];
                        end
                    end
                    SHIFT: begin
                        if (w_pulse_rise) begin
                            r_shreg <= {1'b1, r_shreg[7:1]};
                            if (r_idx == NES_LAST_BIT) begin
                                r_state <= DONE;
                                r_data  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_idx   <= 3'd0;
                            end else begin
                                r_data <= r_shreg[1];
                                r_idx  <= r_idx + 3'd1;
                            end
                        end
                    end
                    default: begin
                        // IDLE and DONE hold; only a latch rise leaves them.
                    end
                endcase
            end
        end
    end

    assign nes_data   = r_data;
    assign busy       = r_busy;
    assign frame_done = r_done;
    assign bit_index  = r_idx;

endmodule

// File: tb/tb_nes_controller_responder.sv
// Self-checking bench for nes_controller_responder. A protocol-level model
// (pin history delayed by the synchronizer latency, captured button byte,
// delivered-bit count) is compared with the DUT every cycle, and directed
// scenarios add hand-computed literal expectations.
module tb_nes_controller_responder;

    localparam int S  = 2;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       nes_latch;
    logic       nes_pulse;
    logic [7:0] buttons;
    logic       nes_data;
    logic       busy;
    logic       frame_done;
    logic [2:0] bit_index;

    int n_checks = 0;
    int n_errors = 0;
    int fd_seen  = 0;

    always #5 clk = ~clk;

    nes_controller_responder #(
        .SYNC_STAGES    (S),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .nes_latch  (nes_latch),
        .nes_pulse  (nes_pulse),
        .buttons    (buttons),
        .nes_data   (nes_data),
        .busy       (busy),
        .frame_done (frame_done),
        .bit_index  (bit_index)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- protocol model ----------------
    localparam int M_IDLE = 0, M_LOAD = 1, M_SHIFT = 2, M_DONE = 3;
    int         m_mode;
    logic [7:0] m_cap;
    int         m_pos;
    logic       m_fd;
    int         m_quiet;
    logic [S+2:0] hl, hp;

    task automatic model_step();
        logic lr, lf, pr, pf, any, was_busy, tmo;
        if (reset) begin
            m_mode = M_IDLE; m_cap = 8'h00; m_pos = 0; m_fd = 1'b0; m_quiet = 0;
            hl = '0; hp = '0;
            return;
        end
        // hl[j] is the latch pin as sampled j edges ago.
        hl = {hl[S+1:0], nes_latch};
        hp = {hp[S+1:0], nes_pulse};
        lr = hl[S+1] & ~hl[S+2];
        lf = ~hl[S+1] & hl[S+2];
        pr = hp[S+1] & ~hp[S+2];
        pf = ~hp[S+1] & hp[S+2];
        any = lr | lf | pr | pf;
        was_busy = (m_mode == M_LOAD) || (m_mode == M_SHIFT);
        tmo = 1'b0;
`ifdef NES_TIMEOUT_EN
        if (any || !was_busy) m_quiet = 0;
        else if (m_quiet == TO - 1) begin tmo = 1'b1; m_quiet = 0; end
        else m_quiet++;
`else
        if (any && was_busy) m_quiet = 0;
`endif
        m_fd = 1'b0;
        if (lr) begin
            m_mode = M_LOAD; m_cap = buttons; m_pos = 0;
        end else if (tmo) begin
            m_mode = M_IDLE; m_pos = 0;
        end else if (m_mode == M_LOAD) begin
            if (lf) m_mode = M_SHIFT;
            else    m_cap = buttons;
        end else if (m_mode == M_SHIFT && pr) begin
            m_pos++;
            if (m_pos == 8) begin m_mode = M_DONE; m_pos = 0; m_fd = 1'b1; end
        end
    endtask

    // Model update on each active edge, DUT comparison 2 time units later.
    initial begin
        forever begin
            logic m_busy, m_data;
            @(posedge clk);
            model_step();
            #2;
            if (!reset) begin
                m_busy = (m_mode == M_LOAD) || (m_mode == M_SHIFT);
                m_data = m_busy ? ~m_cap[m_pos] : 1'b1;
                check("model nes_data",   32'(nes_data),   32'(m_data));
                check("model busy",       32'(busy),       32'(m_busy));
                check("model bit_index",  32'(bit_index),  32'(m_pos));
                check("model frame_done", 32'(frame_done), 32'(m_fd));
                if (frame_done) fd_seen++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_pulse();
        nes_pulse = 1'b1; step(8);
        nes_pulse = 1'b0; step(8);
    endtask

    task automatic start_frame(input logic [7:0] b);
        buttons = b; nes_latch = 1'b1; step(12);
        nes_latch = 1'b0; step(8);
    endtask

    task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input int hold,
                             input int switch_at, output logic [7:0] seen, output logic tail);
        buttons = b0; nes_latch = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (i == switch_at) buttons = b1;
            step(1);
        end
        nes_latch = 1'b0; step(8);
        for (int i = 0; i < 8; i++) begin
            seen[i] = nes_data;
            host_pulse();
        end
        tail = nes_data;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [7:0] seen;
        logic       tail;
        int         fd0;

        reset = 1'b1; nes_latch = 1'b0; nes_pulse = 1'b0; buttons = 8'h00;
        step(3);
        check("reset nes_data",   32'(nes_data),   32'd1);
        check("reset busy",       32'(busy),       32'd0);
        check("reset bit_index",  32'(bit_index),  32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0; step(2);

        // A only: active-low stream 0,1,1,1,1,1,1,1 then released.
        fd0 = fd_seen;
        run_frame(8'h01, 8'h01, 12, -1, seen, tail);
        check("A-only sequence",   32'(seen), 32'hFE);
        check("A-only tail",       32'(tail), 32'd1);
        check("A-only frame_done", 32'(fd_seen - fd0), 32'd1);
        check("A-only bit_index",  32'(bit_index), 32'd0);
        check("A-only busy",       32'(busy), 32'd0);

        // Buttons change mid-latch: the last latch-high value 8'h3C is shifted.
        fd0 = fd_seen;
        run_frame(8'hA5, 8'h3C, 20, 10, seen, tail);
        check("late capture sequence",   32'(seen), 32'hC3);
        check("late capture tail",       32'(tail), 32'd1);
        check("late capture frame_done", 32'(fd_seen - fd0), 32'd1);

        // Abort after 3 pulses by re-latching.
        start_frame(8'h01);
        repeat (3) host_pulse();
        check("abort pre bit_index", 32'(bit_index), 32'd3);
        check("abort pre nes_data",  32'(nes_data),  32'd1);
        fd0 = fd_seen;
        nes_latch = 1'b1; step(3);
        check("abort 3 cycles nes_data", 32'(nes_data), 32'd1);
        step(1);
        check("abort 4 cycles nes_data",  32'(nes_data),  32'd0);
        check("abort 4 cycles busy",      32'(busy),      32'd1);
        check("abort 4 cycles bit_index", 32'(bit_index), 32'd0);
        nes_latch = 1'b0; step(8);
        check("abort no frame_done", 32'(fd_seen - fd0), 32'd0);
        check("abort restart data",  32'(nes_data), 32'd0);

        // Reset mid-shift at bit 5.
        repeat (5) host_pulse();
        check("pre-reset bit_index", 32'(bit_index), 32'd5);
        reset = 1'b1; #1;
        check("async reset nes_data",  32'(nes_data),  32'd1);
        check("async reset busy",      32'(busy),      32'd0);
        check("async reset bit_index", 32'(bit_index), 32'd0);
        step(1);
        reset = 1'b0; step(2);
        repeat (3) host_pulse();
        check("idle pulses bit_index", 32'(bit_index), 32'd0);
        check("idle pulses nes_data",  32'(nes_data),  32'd1);
        check("idle pulses busy",      32'(busy),      32'd0);

        // All pressed, then extra pulses in DONE.
        fd0 = fd_seen;
        run_frame(8'hFF, 8'hFF, 12, -1, seen, tail);
        check("all pressed sequence", 32'(seen), 32'h00);
        repeat (2) host_pulse();
        check("done pulses bit_index",  32'(bit_index), 32'd0);
        check("done pulses nes_data",   32'(nes_data),  32'd1);
        check("done pulses frame_done", 32'(fd_seen - fd0), 32'd1);

        // Pulses while latch is high are ignored.
        buttons = 8'h02; nes_latch = 1'b1; step(10);
        repeat (2) host_pulse();
        check("latch-high pulses bit_index", 32'(bit_index), 32'd0);
        check("latch-high pulses nes_data",  32'(nes_data),  32'd1);
        check("latch-high pulses busy",      32'(busy),      32'd1);
        nes_latch = 1'b0; step(8);
        host_pulse();
        check("B after first pulse nes_data",  32'(nes_data),  32'd0);
        check("B after first pulse bit_index", 32'(bit_index), 32'd1);
        fd0 = fd_seen;
        repeat (7) host_pulse();
        check("B frame frame_done", 32'(fd_seen - fd0), 32'd1);

        // Host stalls after 2 pulses.
        fd0 = fd_seen;
        start_frame(8'h04);
        repeat (2) host_pulse();
        step(80);
`ifdef NES_TIMEOUT_EN
        check("stall busy",      32'(busy),      32'd0);
        check("stall nes_data",  32'(nes_data),  32'd1);
        check("stall bit_index", 32'(bit_index), 32'd0);
`else
        check("stall busy",      32'(busy),      32'd1);
        check("stall nes_data",  32'(nes_data),  32'd0);
        check("stall bit_index", 32'(bit_index), 32'd2);
`endif
        check("stall frame_done", 32'(fd_seen - fd0), 32'd0);

        step(4);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/nes_controller_responder.md
Name: nes_controller_responder

Overview:
- Device-side emulation of an NES gamepad, the serial responder to the NES host reader FSM.
- Samples 8 local button levels on the host latch and shifts them out on the data line, one bit per host clock pulse.
- Data line is active-low: pressed = 0, released = 1.
- Sits between the board button/joystick inputs and the NES connector pins. Lets a second board, or a self-test loopback, drive the Pong controller inputs.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each asynchronous host input (min 2).
- TIMEOUT_CYCLES, 4096, idle clk cycles in a frame before abort. Used only when NES_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, single clock domain.
- reset  input  1  asynchronous, active-high reset.
- nes_latch  input  1  host latch, asynchronous to clk, active-high.
- nes_pulse  input  1  host clock (pulse), asynchronous to clk; rising edge advances the shift.
- buttons  input  8  pressed=1. Bit order: [0]=A, [1]=B, [2]=Select, [3]=Start, [4]=Up, [5]=Down, [6]=Left, [7]=Right.
- nes_data  output  1  serial data to host, active-low.
- busy  output  1  high while in LOAD or SHIFT.
- frame_done  output  1  one-cycle pulse on the 8th shift.
- bit_index  output  3  index of the bit currently on nes_data.

Behaviour:
- Reset values (asynchronous assertion): state=IDLE, shift register=8'hFF (all released), nes_data=1, bit_index=0, busy=0, frame_done=0, synchronizer flops=0.
- Input conditioning:
  - nes_latch and nes_pulse each pass through SYNC_STAGES flops plus one edge-detect flop.
  - A synchronized edge therefore reaches the FSM SYNC_STAGES+1 clk cycles after the pin edge.
  - nes_data updates one cycle after that: 4 cycles total at default.
  - The host must hold each pulse level at least SYNC_STAGES+2 clk cycles.
- shreg[7:0] holds the inverted buttons; nes_data = shreg[0] in LOAD/SHIFT, otherwise 1.
- IDLE:
  - nes_data=1; pulse edges are ignored.
  - Latch rise -> LOAD.
- LOAD:
  - shreg <= ~buttons every cycle while the synchronized latch is high. The captured value is the buttons sampled on the last latch-high cycle.
  - nes_data shows ~A from the first LOAD cycle.
  - Latch fall -> SHIFT with bit_index=0.
- SHIFT:
  - On each pulse rise: shreg <= {1'b1, shreg[7:1]} and bit_index++.
  - On the rise with bit_index==7: go to DONE, assert frame_done for 1 cycle, set bit_index to 0.
- DONE:
  - nes_data=1 (a released bit shifted in); further pulses are ignored.
  - Latch rise -> LOAD.
- Latch rise in any state restarts LOAD, aborting a partial frame without asserting frame_done.
- A latch edge and a pulse edge in the same cycle: the latch edge wins and the pulse edge is dropped.
- A pulse rise while the latch is high (LOAD) is ignored.
- Reset mid-frame: immediate return to reset values; the next frame needs a fresh latch.
- One full host frame is 2 latch states plus 8 pulses, which matches the host sequence A..Right plus the trailing pulse.

Optional Feature:
- Macro NES_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every synchronized latch or pulse edge and increments while in LOAD or SHIFT.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, nes_data=1, no frame_done.
  - Guards against a host that stalls or is unplugged.
- Undefined: no counter; LOAD/SHIFT wait indefinitely for host edges.

Decomposition:
- Package nes_pkg:
  - state encoding IDLE/LOAD/SHIFT/DONE (2 bits);
  - button index constants BTN_A..BTN_RIGHT (0..7);
  - NES_FRAME_BITS=8.
- Sub-module nes_sync_edge:
  - parameter SYNC_STAGES;
  - ports clk, reset, async_in, sync_out, rise, fall;
  - instantiated once for nes_latch and once for nes_pulse.

Test Plan:
- buttons=8'b0000_0001 (A only), full frame with 8 pulses of 8 clk per half-period -> nes_data sequence 0,1,1,1,1,1,1,1, then 1 after the 8th pulse; frame_done pulses once; bit_index returns to 0.
- buttons=8'b1010_0101, latch held 20 cycles while buttons change to 8'h3C on cycle 10 -> shifted sequence matches ~8'h3C LSB first: 1,1,0,0,0,0,1,1.
- Latch re-asserted after 3 pulses -> frame aborted, no frame_done, nes_data returns to ~buttons[0] within 4 cycles of the latch pin edge.
- Reset asserted mid-SHIFT (bit_index=5) -> same cycle: nes_data=1, busy=0, bit_index=0; pulses ignored until the next latch.
- Pulses in IDLE/DONE and during latch-high -> no change to nes_data or bit_index.
- NES_TIMEOUT_EN, TIMEOUT_CYCLES=64: latch, then 2 pulses, then silence -> IDLE after 64 cycles, busy=0, no frame_done. Without the macro -> stays in SHIFT.
